// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants and bundle types for the fetch stage and IF/ID register.
// Holds field slices, state encoding and the IF/ID payload layout.
package if_id_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] KILL  = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_hazard.sv
// Load-use hazard compare against the IF/ID operands.
// Also keeps a saturating count of stall cycles.
module load_use_detect
  import if_id_fetch_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_regwr,
  input  logic [4:0]       ex_rt,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic ex_load;
  logic hit;

  assign ex_load = ex_memtoreg & ex_regwr & (ex_rt != 5'd0);
  // rt is compared even for formats that do not read it
  assign hit     = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign stall   = id_valid & ex_load & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC, imem request port, one-entry skid buffer, IF/ID register.
// Redirects abandon an in-flight fetch through the KILL state.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             ex_memtoreg,
  input  logic             ex_regwr,
  input  logic [4:0]       ex_rt,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam if_id_t BUBBLE = '{
    valid: 1'b0,
    instr: NOP_INSTR,
    pc4:   32'h0
  };

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] kill_addr;
  logic [31:0] pc_plus4;
  logic        fire;
  if_id_t      ifid;
  if_id_t      skid;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    imem_req  = 1'b1;
    imem_addr = pc;
    if (state == KILL) begin
      imem_addr = kill_addr;
    end else begin
      imem_req  = !skid.valid;
    end
  end

  assign fire = imem_req & imem_ready;

  assign id_valid    = ifid.valid;
  assign id_instr    = ifid.instr;
  assign id_pc_plus4 = ifid.pc4;

  load_use_detect #(
    .CNT_W(CNT_W)
  ) u_lud (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (ifid.valid),
    .id_rs      (ifid.instr[RS_HI:RS_LO]),
    .id_rt      (ifid.instr[RT_HI:RT_LO]),
    .ex_memtoreg(ex_memtoreg),
    .ex_regwr   (ex_regwr),
    .ex_rt      (ex_rt),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      kill_addr <= RESET_PC;
      ifid      <= BUBBLE;
      skid      <= BUBBLE;
    end else if (state == FETCH) begin
      if (redirect_valid) begin
        pc         <= redirect_pc;
        ifid       <= BUBBLE;
        skid.valid <= 1'b0;
        if (imem_req && !imem_ready) begin
          kill_addr <= pc;
          state     <= KILL;
        end
      end else if (!stall && skid.valid) begin
        ifid       <= '{valid: 1'b1, instr: skid.instr, pc4: skid.pc4};
        skid.valid <= 1'b0;
      end else if (fire && !stall) begin
        ifid <= '{valid: 1'b1, instr: imem_rdata, pc4: pc_plus4};
        pc   <= pc_plus4;
      end else if (fire && stall) begin
        // ID is frozen; park the returning word until it can move
        skid <= '{valid: 1'b1, instr: imem_rdata, pc4: pc_plus4};
        pc   <= pc_plus4;
      end else if (!stall) begin
        ifid <= BUBBLE;
      end
    end else begin
      ifid <= BUBBLE;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end
      if (imem_ready) begin
        state <= FETCH;
      end
    end
  end

endmodule
